// File: rtl/aib_tx_framer.sv
// AIB transmit framer: splits 72-bit flits into two 40-bit beats on two 20-bit lanes,
// sends a word-alignment training pattern after reset, and gates sends on far-end credits.
module aib_tx_framer #(
    parameter int unsigned CREDITS     = 8,
    parameter int unsigned TRAIN_BEATS = 64,
    localparam int unsigned CREDIT_W   = $clog2(CREDITS + 1)
) (
    input  logic                i_aib_tx_clk,
    input  logic                i_rst_n,
    input  logic                c_bypass_word_align,
    input  logic                i_tx_valid,
    output logic                o_tx_ready,
    input  logic [71:0]         i_tx_data,
    input  logic                i_credit_return,
    output logic [19:0]         o_aib_tx_data0,
    output logic [19:0]         o_aib_tx_data1,
    output logic                o_train_done,
    output logic [CREDIT_W-1:0] o_credits
);

    // Counter needs at least one bit even for a single training beat.
    localparam int unsigned TCNT_W = (TRAIN_BEATS > 1) ? $clog2(TRAIN_BEATS) : 1;

    localparam logic [39:0]         TRAIN_BEAT  = 40'hFFFFF_00000;
    localparam logic [39:0]         IDLE_BEAT   = 40'h0;
    localparam logic [CREDIT_W-1:0] CREDITS_MAX = CREDIT_W'(CREDITS);
    localparam logic [TCNT_W-1:0]   TCNT_LAST   = TCNT_W'(TRAIN_BEATS - 1);

    typedef enum logic [1:0] {
        StTrain,
        StIdle,
        StBeatB
    } state_e;

    state_e              state_q, state_d;
    logic [39:0]         beat_q, beat_d;
    logic [35:0]         hi_q, hi_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic                train_done_q, train_done_d;
    logic [CREDIT_W-1:0] credits_q, credits_d;
    logic                tx_ready;
    logic                accept;
    logic                train_last;

    // Assemble a beat: {sof, valid, parity, 0, payload}.
    function automatic logic [39:0] make_beat(input logic sof, input logic [35:0] payload);
        return {sof, 1'b1, ^payload, 1'b0, payload};
    endfunction

    assign train_last = (tcnt_q == TCNT_LAST);
    assign accept     = i_tx_valid & tx_ready;

    // State register; bypass config picks the post-reset state.
    always_ff @(posedge i_aib_tx_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= c_bypass_word_align ? StIdle : StTrain;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StTrain: if (train_last) state_d = StIdle;
            StIdle:  if (accept)     state_d = StBeatB;
            StBeatB: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output / datapath next-state logic.
    always_comb begin
        // train_done_q gates ready so nothing is accepted before the first edge in bypass.
        tx_ready     = (state_q == StIdle) && train_done_q && (credits_q != '0);
        beat_d       = IDLE_BEAT;
        hi_d         = hi_q;
        tcnt_d       = tcnt_q;
        train_done_d = train_done_q;
        unique case (state_q)
            StTrain: begin
                beat_d = TRAIN_BEAT;
                tcnt_d = tcnt_q + 1'b1;
                if (train_last) train_done_d = 1'b1;
            end
            StIdle: begin
                train_done_d = 1'b1;
                if (accept) begin
                    beat_d = make_beat(1'b1, i_tx_data[35:0]);
                    hi_d   = i_tx_data[71:36];
                end
            end
            StBeatB: beat_d = make_beat(1'b0, hi_q);
            default: beat_d = IDLE_BEAT;
        endcase
    end

    // Credit counter: accept consumes, return refills, saturating at CREDITS.
    always_comb begin
        credits_d = credits_q;
        if (accept && !i_credit_return) begin
            credits_d = credits_q - 1'b1;
        end else if (i_credit_return && !accept && (credits_q != CREDITS_MAX)) begin
            credits_d = credits_q + 1'b1;
        end
    end

    // Datapath registers; reset discards any half-sent flit.
    always_ff @(posedge i_aib_tx_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            beat_q       <= IDLE_BEAT;
            hi_q         <= '0;
            tcnt_q       <= '0;
            train_done_q <= 1'b0;
            credits_q    <= CREDITS_MAX;
        end else begin
            beat_q       <= beat_d;
            hi_q         <= hi_d;
            tcnt_q       <= tcnt_d;
            train_done_q <= train_done_d;
            credits_q    <= credits_d;
        end
    end

    assign o_tx_ready     = tx_ready;
    assign o_aib_tx_data0 = beat_q[19:0];
    assign o_aib_tx_data1 = beat_q[39:20];
    assign o_train_done   = train_done_q;
    assign o_credits      = credits_q;

endmodule

// File: tb/tb_aib_tx_framer.sv
// Self-checking bench for aib_tx_framer: directed scenarios plus random traffic,
// compared against a queue-based beat model.
module tb_aib_tx_framer;

    localparam int CREDITS     = 8;
    localparam int TRAIN_BEATS = 64;
    localparam logic [39:0] TRAIN_PAT = 40'hFFFFF_00000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bypass;
    logic        valid;
    logic        ready;
    logic [71:0] data;
    logic        ret;
    logic [19:0] d0;
    logic [19:0] d1;
    logic        train_done;
    logic [3:0]  credits;

    always #5 clk = ~clk;

    aib_tx_framer #(
        .CREDITS     (CREDITS),
        .TRAIN_BEATS (TRAIN_BEATS)
    ) dut (
        .i_aib_tx_clk        (clk),
        .i_rst_n             (rst_n),
        .c_bypass_word_align (bypass),
        .i_tx_valid          (valid),
        .o_tx_ready          (ready),
        .i_tx_data           (data),
        .i_credit_return     (ret),
        .o_aib_tx_data0      (d0),
        .o_aib_tx_data1      (d1),
        .o_train_done        (train_done),
        .o_credits           (credits)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: beats waiting to go out, credits, training progress.
    logic [39:0] m_q[$];
    logic [39:0] m_out;
    int          m_credits;
    int          m_train_left;
    bit          m_trained;

    function automatic logic [39:0] beat(input bit sof, input logic [35:0] p);
        return {sof, 1'b1, ^p, 1'b0, p};
    endfunction

    function automatic logic [71:0] rand72();
        return {8'($urandom), $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input bit byp);
        m_q.delete();
        m_out        = '0;
        m_credits    = CREDITS;
        m_train_left = byp ? 0 : TRAIN_BEATS;
        m_trained    = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_beat"}, {d1, d0}, m_out);
        chk({tag, "_train_done"}, {39'b0, train_done}, {39'b0, m_trained});
        chk({tag, "_credits"}, {36'b0, credits}, 40'(m_credits));
    endtask

    // One clock cycle: apply inputs, check ready, advance model, check registered outputs.
    task automatic step(input bit v, input logic [71:0] d, input bit r);
        bit m_ready;
        bit acc;
        valid = v;
        data  = d;
        ret   = r;
        #1;
        m_ready = m_trained && (m_q.size() == 0) && (m_credits != 0);
        chk("ready", {39'b0, ready}, {39'b0, m_ready});
        acc = v && m_ready;
        if (acc) begin
            m_q.push_back(beat(1'b1, d[35:0]));
            m_q.push_back(beat(1'b0, d[71:36]));
        end
        if (acc && !r) m_credits--;
        else if (r && !acc && m_credits < CREDITS) m_credits++;
        if (m_train_left > 0) begin
            m_out = TRAIN_PAT;
            m_train_left--;
            if (m_train_left == 0) m_trained = 1'b1;
        end else begin
            m_trained = 1'b1;
            m_out     = (m_q.size() != 0) ? m_q.pop_front() : 40'h0;
        end
        @(posedge clk);
        #1;
        check_outputs("cyc");
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset(input bit byp);
        bypass = byp;
        valid  = 1'b0;
        ret    = 1'b0;
        rst_n  = 1'b0;
        #1;
        model_reset(byp);
        check_outputs("rst");
        chk("rst_ready", {39'b0, ready}, 40'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        bypass = 1'b0;
        valid  = 1'b0;
        data   = '0;
        ret    = 1'b0;
        model_reset(1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_outputs("por");
        rst_n = 1'b1;

        // Training: 64 beats with ready low, then idle.
        step(1'b1, rand72(), 1'b0);
        chk("train_first", {d1, d0}, TRAIN_PAT);
        for (int i = 1; i < TRAIN_BEATS; i++) step(1'b0, '0, 1'b0);
        chk("train_done_64", {39'b0, train_done}, 40'h1);
        step(1'b0, '0, 1'b0);
        chk("idle_after_train", {d1, d0}, 40'h0);

        // Known flit.
        step(1'b1, 72'h123456789ABCDEF012, 1'b0);
        chk("beatA_known", {d1, d0}, {20'hEABCD, 20'hEF012});
        step(1'b0, '0, 1'b0);
        chk("beatB_known", {d1, d0}, {20'h61234, 20'h56789});
        chk("credits_7", {36'b0, credits}, 40'd7);

        // Drain credits with valid held high.
        for (int i = 0; i < 18; i++) step(1'b1, rand72(), 1'b0);
        chk("credits_0", {36'b0, credits}, 40'd0);
        chk("ready_0", {39'b0, ready}, 40'd0);
        step(1'b1, rand72(), 1'b1);
        chk("credit_back_1", {36'b0, credits}, 40'd1);
        step(1'b1, rand72(), 1'b0);
        step(1'b0, '0, 1'b0);

        // Simultaneous accept and return at 3 credits; saturation at 8.
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        step(1'b1, rand72(), 1'b1);
        chk("credits_hold_3", {36'b0, credits}, 40'd3);
        step(1'b0, '0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
        chk("credits_sat_8", {36'b0, credits}, 40'd8);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), rand72(), 1'($urandom_range(0, 2) == 0));

        // Reset while Beat A is on the pins.
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b1, rand72(), 1'b0);
        do_reset(1'b0);
        chk("midrst_beat", {d1, d0}, 40'h0);
        step(1'b0, '0, 1'b0);
        chk("retrain_first", {d1, d0}, TRAIN_PAT);
        for (int i = 1; i < TRAIN_BEATS + 2; i++) step(1'b0, '0, 1'b0);

        // Bypass reset: no training; bypass changes afterwards have no effect.
        do_reset(1'b1);
        step(1'b1, rand72(), 1'b0);
        chk("byp_done", {39'b0, train_done}, 40'h1);
        chk("byp_beat", {d1, d0}, 40'h0);
        bypass = 1'b0;
        for (int i = 0; i < 150; i++)
            step(1'($urandom_range(0, 1)), rand72(), 1'($urandom_range(0, 3) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
